// File: rtl/crack_sched.sv
`default_nettype none
// ============================================================================
//  Module   : crack_sched
//  Purpose  : Launches and supervises NUM_CORES parallel crack cores. Each
//             core searches its own interleaved key subset. The first valid
//             key is latched and the remaining cores are halted. A global
//             failure is reported when every core finishes without a key.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock
//    rst_n          in   asynchronous active-low reset
//    en             in   start request, accepted only while rdy=1
//    rdy            out  idle or finished, ready for en
//    key            out  recovered key, valid while key_valid=1
//    key_valid      out  search succeeded
//    fail           out  search finished with no key
//    timeout        out  watchdog expired (tied 0 without the watchdog)
//    cycles         out  RUN-state cycle count, saturating at 2^32-1
//    core_rst_n     out  per-core synchronous reset, active low
//    core_en        out  per-core one-cycle start pulse
//    core_rdy       in   per-core finished flag
//    core_key       in   per-core key, core i at [i*KEY_W +: KEY_W]
//    core_key_valid in   per-core key found flag
//  Configuration
//    CRACK_SCHED_TIMEOUT_EN : when defined, a RUN that reaches TIMEOUT_CYCLES
//                             cycles without a find ends in FAILED with
//                             timeout=1. Undefined: no watchdog.
// ============================================================================
module crack_sched #(
    parameter int          NUM_CORES      = 2,
    parameter int          KEY_W          = 24,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic                       rdy,
    output logic [KEY_W-1:0]           key,
    output logic                       key_valid,
    output logic                       fail,
    output logic                       timeout,
    output logic [31:0]                cycles,
    output logic [NUM_CORES-1:0]       core_rst_n,
    output logic [NUM_CORES-1:0]       core_en,
    input  logic [NUM_CORES-1:0]       core_rdy,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic [NUM_CORES-1:0]       core_key_valid
);

    localparam logic [NUM_CORES-1:0] c_ALL_CORES  = {NUM_CORES{1'b1}};
    localparam logic [31:0]          c_CYCLES_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_FOUND  = 3'd4,
        S_FAILED = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_CORES-1:0]  r_active;
    logic [NUM_CORES-1:0]  w_active_nxt;
    logic [NUM_CORES-1:0]  w_hits;
    logic                  w_hit_any;
    logic [KEY_W-1:0]      w_hit_key;
    logic [31:0]           w_cycles_inc;
    logic                  w_expired;

    logic                  r_rdy;
    logic [KEY_W-1:0]      r_key;
    logic                  r_key_valid;
    logic                  r_fail;
    logic [31:0]           r_cycles;
    logic [NUM_CORES-1:0]  r_core_rst_n;
    logic [NUM_CORES-1:0]  r_core_en;

    // ------------------------------------------------------------------
    // Find / retire detection. Only cores still in the active mask count;
    // a core that already reported failure is ignored from then on.
    // ------------------------------------------------------------------
    always_comb begin
        w_hits    = r_active & core_key_valid;
        w_hit_any = |w_hits;
        w_hit_key = '0;
        // Descending scan so the lowest-index hit is the final assignment.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_hit_key = core_key[i*KEY_W +: KEY_W];
            end
        end
        w_active_nxt = r_active & ~(core_rdy & ~core_key_valid);
    end

    assign w_cycles_inc = (r_cycles == c_CYCLES_MAX) ? r_cycles : r_cycles + 32'd1;

`ifdef CRACK_SCHED_TIMEOUT_EN
    // Compare against the post-increment count so the search stops with
    // cycles equal to TIMEOUT_CYCLES.
    assign w_expired = (w_cycles_inc >= TIMEOUT_CYCLES);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_expired            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A find always beats failure or watchdog expiry.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_CRST;
            end
            S_CRST:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_hit_any) begin
                    w_state_nxt = S_FOUND;
                end else if ((w_active_nxt == '0) || w_expired) begin
                    w_state_nxt = S_FAILED;
                end
            end
            S_FOUND, S_FAILED: begin
                if (en) w_state_nxt = S_CRST;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so every output
    // changes on the same edge as the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy        <= 1'b1;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_fail       <= 1'b0;
            r_cycles     <= '0;
            r_core_rst_n <= '0;
            r_core_en    <= '0;
            r_active     <= '0;
        end else begin
            r_rdy        <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FOUND) ||
                            (w_state_nxt == S_FAILED);
            r_key_valid  <= (w_state_nxt == S_FOUND);
            r_fail       <= (w_state_nxt == S_FAILED);
            r_core_rst_n <= ((w_state_nxt == S_START) || (w_state_nxt == S_RUN)) ?
                            c_ALL_CORES : '0;
            r_core_en    <= (w_state_nxt == S_START) ? c_ALL_CORES : '0;

            if (r_state == S_START) begin
                r_active <= c_ALL_CORES;
            end else if (r_state == S_RUN) begin
                r_active <= w_active_nxt;
                r_cycles <= w_cycles_inc;
                if (w_hit_any) r_key <= w_hit_key;
            end

            // A new search always starts counting from zero.
            if ((r_state == S_IDLE) || (w_state_nxt == S_CRST)) begin
                r_cycles <= '0;
            end
        end
    end

`ifdef CRACK_SCHED_TIMEOUT_EN
    logic r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_timeout <= !w_hit_any && w_expired;
        end else if (w_state_nxt != S_FAILED) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign rdy        = r_rdy;
    assign key        = r_key;
    assign key_valid  = r_key_valid;
    assign fail       = r_fail;
    assign cycles     = r_cycles;
    assign core_rst_n = r_core_rst_n;
    assign core_en    = r_core_en;

endmodule
`default_nettype wire
